muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, which sets the operand width and the width of each of HI and LO; legal values are 8 to 64, even only.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit: a request to begin an operation; it is sampled only in IDLE.
REQ-005 The block SHALL have the port op, input, 2 bits, with the encoding 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 The block SHALL have the port a, input, WIDTH bits: multiplicand, or dividend (the RS value).
REQ-007 The block SHALL have the port b, input, WIDTH bits: multiplier, or divisor (the RT value).
REQ-008 The block SHALL have the port busy, output, 1 bit: high in any state other than IDLE.
REQ-009 The block SHALL have the port done, output, 1 bit: a one-cycle pulse when the result is valid or when an operation is aborted.
REQ-010 The block SHALL have the port hi, output, WIDTH bits: the registered HI value (product upper half, or remainder).
REQ-011 The block SHALL have the port lo, output, WIDTH bits: the registered LO value (product lower half, or quotient).
REQ-012 The block SHALL have the port div_zero, output, 1 bit: registered; it is high while done is high when a DIV or DIVU had b==0.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, FIX and DONE.
REQ-014 When in IDLE with start=1 at an edge, the block SHALL latch a, b and op, record the operand signs, load the iteration counter with WIDTH, and go to RUN.
REQ-015 Signed ops SHALL iterate on operand magnitudes; unsigned ops SHALL use the operands unchanged.
REQ-016 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, decrement the counter, and go to FIX when the counter reaches 1.
REQ-017 FIX SHALL apply the sign correction in one cycle: a negated product when the operand signs differ, a negated quotient when the signs differ, and a remainder carrying the dividend's sign.
REQ-018 DONE SHALL write hi and lo, assert done for exactly one cycle, and return to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the cycle following the (WIDTH+2)th rising edge after the start edge, independent of operand values.
REQ-020 For DIV or DIVU with b==0, the block SHALL go from IDLE directly to DONE, set div_zero=1, and leave hi and lo unchanged, so done appears 1 cycle after start.
REQ-021 Signed DIV of the most negative value by -1 SHALL yield lo=most negative value and hi=0, with no flag.
REQ-022 Signed division SHALL truncate toward zero.
REQ-023 The product SHALL be the full 2*WIDTH bits, split hi = upper half and lo = lower half.
REQ-024 start while busy=1 SHALL be ignored; it is neither queued nor able to corrupt the operation in flight.
REQ-025 start held high through DONE SHALL begin a new operation only on the first edge in IDLE; back-to-back operations therefore cost WIDTH+3 cycles each.
REQ-026 hi and lo SHALL hold their values between operations and SHALL change only in the DONE cycle.
REQ-027 div_zero SHALL clear on the next accepted start.

Reset
REQ-028 Reset low SHALL immediately force the state to IDLE and set busy=0, done=0, div_zero=0, hi=0, lo=0, and clear the counter and internal accumulators.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no done pulse is produced after release.
REQ-030 The first start SHALL be accepted on the first rising edge with reset high.

Configuration
REQ-031 The block SHALL support the macro MULDIV_UNSIGNED_EN.
REQ-032 When MULDIV_UNSIGNED_EN is defined, op[0] SHALL select unsigned operation as specified above.
REQ-033 When MULDIV_UNSIGNED_EN is undefined, op[0] SHALL be ignored; all operations are signed, the unsigned datapath is not built, and MULTU and DIVU behave as MULT and DIV.

Verification (WIDTH=32, MULDIV_UNSIGNED_EN defined unless stated)
REQ-034 Bench: MULT a=7, b=0xFFFFFFFD -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 Bench: MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; without the macro, the same stimulus -> hi=0, lo=1.
REQ-036 Bench: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Bench: set hi/lo by a prior op, then DIVU a=5, b=0 -> done 1 cycle after start; div_zero=1; hi and lo hold their prior values; the next start clears div_zero.
REQ-038 Bench: start pulsed again at cycle 10 of a DIV -> ignored; single done at cycle 34 with the correct result.
REQ-039 Bench: reset pulled low at cycle 15 of a MULT -> busy=0, hi=lo=0 immediately; no done after release; a new MULT 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add MULT, restoring DIV, fixed WIDTH+2 cycle latency.
// Optional macro MULDIV_UNSIGNED_EN builds the unsigned path (op[0]); otherwise all ops are signed.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 signed_op_s, sa_s, sb_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       mul_sum_s, div_top_s, div_trial_s;
  logic                 div_ok_s;
  logic [WIDTH-1:0]     div_rem_s;

`ifdef MULDIV_UNSIGNED_EN
  assign signed_op_s = ~op[0];
`else
  logic op0_unused_s;
  assign op0_unused_s = op[0];
  assign signed_op_s  = 1'b1;
`endif

  assign sa_s    = signed_op_s & a[WIDTH-1];
  assign sb_s    = signed_op_s & b[WIDTH-1];
  assign a_mag_s = cond_neg(a, sa_s);
  assign b_mag_s = cond_neg(b, sb_s);

  // Multiply step adds m into the upper half; divide step trial-subtracts m from the shifted remainder.
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign div_top_s   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial_s = div_top_s - {1'b0, m_q};
  assign div_ok_s    = ~div_trial_s[WIDTH];
  assign div_rem_s   = div_ok_s ? div_trial_s[WIDTH-1:0] : div_top_s[WIDTH-1:0];

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      m_q       <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dz_d      = 1'b0;
          is_div_d  = op[1];
          neg_res_d = sa_s ^ sb_s;
          neg_rem_d = sa_s;
          cnt_d     = CW'(WIDTH);
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
          m_d       = op[1] ? b_mag_s : a_mag_s;
          zero_d    = op[1] && (b == {WIDTH{1'b0}});
          if (op[1] && (b == {WIDTH{1'b0}})) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = {div_rem_s, acc_q[WIDTH-2:0], div_ok_s};
        end else begin
          acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        if (is_div_q) begin
          acc_d = {cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q),
                   cond_neg(acc_q[WIDTH-1:0], neg_res_q)};
        end else if (neg_res_q) begin
          acc_d = {(2*WIDTH){1'b0}} - acc_q;
        end else begin
          acc_d = acc_q;
        end
        state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        if (zero_q) begin
          dz_d = 1'b1;
        end else begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit (WIDTH=32) against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_hi = 32'h0, exp_lo = 32'h0;
  logic        exp_dz = 1'b0;
  int          exp_lat;
`ifdef MULDIV_UNSIGNED_EN
  bit          unsigned_en = 1'b1;
`else
  bit          unsigned_en = 1'b0;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero like the spec.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bit     sgn;
    longint sp, sq, sr;
    logic [63:0] up;
    sgn = unsigned_en ? ~o[0] : 1'b1;
    exp_dz  = 1'b0;
    exp_lat = 34;
    if (o[1]) begin
      if (y == 32'h0) begin
        exp_dz  = 1'b1;
        exp_lat = 1;
      end else if (sgn) begin
        sq = longint'($signed(x)) / longint'($signed(y));
        sr = longint'($signed(x)) % longint'($signed(y));
        exp_lo = sq[31:0];
        exp_hi = sr[31:0];
      end else begin
        exp_lo = x / y;
        exp_hi = x % y;
      end
    end else if (sgn) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      exp_hi = sp[63:32];
      exp_lo = sp[31:0];
    end else begin
      up = {32'h0, x} * {32'h0, y};
      exp_hi = up[63:32];
      exp_lo = up[31:0];
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int pulse_at, input string tag);
    int n;
    bit seen;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = exp_hi;
    prev_lo = exp_lo;
    ref_model(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'(1'b1));
    check_eq({tag, "_dzclr"}, 64'(div_zero), 64'(1'b0));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      start = (n == pulse_at);
      if (n == 5 && exp_lat > 5) begin
        check_eq({tag, "_hold_hi"}, 64'(hi), 64'(prev_hi));
        check_eq({tag, "_hold_lo"}, 64'(lo), 64'(prev_lo));
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check_eq({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 64'(done), 64'(1'b0));
    check_eq({tag, "_idle"}, 64'(busy), 64'(1'b0));
  endtask

  initial begin
    int n, dones;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'(1'b0));
    check_eq("rst_done", 64'(done), 64'(1'b0));
    check_eq("rst_hi", 64'(hi), 64'(32'h0));
    check_eq("rst_lo", 64'(lo), 64'(32'h0));
    check_eq("rst_dz", 64'(div_zero), 64'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 32'd7, 32'hFFFFFFFD, 0, "mult_7x-3");
    check_eq("c034_hi", 64'(hi), 64'(32'hFFFFFFFF));
    check_eq("c034_lo", 64'(lo), 64'(32'hFFFFFFEB));

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
    check_eq("c035_hi", 64'(hi), unsigned_en ? 64'(32'hFFFFFFFE) : 64'(32'h0));
    check_eq("c035_lo", 64'(lo), 64'(32'h1));

    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, "div_-7/2");
    check_eq("c036a_lo", 64'(lo), 64'(32'hFFFFFFFD));
    check_eq("c036a_hi", 64'(hi), 64'(32'hFFFFFFFF));
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, "div_min/-1");
    check_eq("c036b_lo", 64'(lo), 64'(32'h80000000));
    check_eq("c036b_hi", 64'(hi), 64'(32'h0));

    do_op(2'b00, 32'd1234, 32'd5678, 0, "mult_pre");
    do_op(2'b11, 32'd5, 32'd0, 0, "divu_by0");
    check_eq("c037_hi", 64'(hi), 64'(32'd0));
    check_eq("c037_lo", 64'(lo), 64'(32'd7006652));
    do_op(2'b00, 32'd2, 32'd3, 0, "after_dz");

    do_op(2'b10, 32'd1000, 32'hFFFFFFF9, 10, "div_restart");
    check_eq("c038_lo", 64'(lo), 64'(32'hFFFFFF72));
    check_eq("c038_hi", 64'(hi), 64'(32'd6));

    // Back-to-back with start held high: second op accepted on the first IDLE edge.
    ref_model(2'b00, 32'd5, 32'd6);
    @(negedge clk);
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("b2b_lat1", 64'(n), 64'(34));
    check_eq("b2b_lo1", 64'(lo), 64'(exp_lo));
    ref_model(2'b11, 32'd100, 32'd7);
    op = 2'b11; a = 32'd100; b = 32'd7;
    n = 0;
    do begin @(posedge clk); #1; n++; start = 1'b0; end while (!done && n < 100);
    check_eq("b2b_gap", 64'(n), 64'(35));
    check_eq("b2b_lo2", 64'(lo), 64'(32'd14));
    check_eq("b2b_hi2", 64'(hi), 64'(32'd2));
    @(negedge clk);

    // Reset at cycle 15 of a MULT discards it.
    @(negedge clk);
    op = 2'b00; a = 32'h12345; b = 32'h6789; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_hi = 32'h0; exp_lo = 32'h0;
    check_eq("rstmid_busy", 64'(busy), 64'(1'b0));
    check_eq("rstmid_hi", 64'(hi), 64'(32'h0));
    check_eq("rstmid_lo", 64'(lo), 64'(32'h0));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    check_eq("rstmid_nodone", 64'(dones), 64'(0));
    do_op(2'b00, 32'd3, 32'd4, 0, "mult_3x4");
    check_eq("c039_lo", 64'(lo), 64'(32'd12));
    check_eq("c039_hi", 64'(hi), 64'(32'd0));

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'h0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFFFFFF;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) rx = 32'h80000000;
      do_op(ro, rx, ry, 0, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
